// File: rtl/buttons_pkg.sv
// Shared constants and the event word layout for the button reader.
package buttons_pkg;

    localparam int NUM_BUTTONS = 4;
    localparam int CNT_WIDTH   = 4;

    typedef struct packed {
        logic [NUM_BUTTONS-1:0] release_m;
        logic [NUM_BUTTONS-1:0] press_m;
    } btn_evt_t;

endpackage

// File: rtl/buttons_reader_if.sv
// Board-side buttons plus the valid/ready event channel toward the consumer.
interface buttons_reader_if;
    import buttons_pkg::*;

    logic [NUM_BUTTONS-1:0]   BTN_IN;
    logic [NUM_BUTTONS-1:0]   LEVEL;
    logic [NUM_BUTTONS-1:0]   PRESS;
    logic [NUM_BUTTONS-1:0]   RELEASE;
    logic                     EVT_VALID;
    logic [2*NUM_BUTTONS-1:0] EVT_DATA;
    logic                     EVT_READY;
    logic                     EVT_OVERRUN;

    // The reader produces levels and events; the consumer supplies EVT_READY.
    modport master (
        input  BTN_IN, EVT_READY,
        output LEVEL, PRESS, RELEASE, EVT_VALID, EVT_DATA, EVT_OVERRUN
    );

    modport slave (
        output BTN_IN, EVT_READY,
        input  LEVEL, PRESS, RELEASE, EVT_VALID, EVT_DATA, EVT_OVERRUN
    );

endinterface

// File: rtl/buttons_reader_debounce_cell.sv
// One button: two-flop synchronizer, tick-driven persistence counter,
// accepted level and single-cycle press/release pulses.
module debounce_cell
    import buttons_pkg::*;
#(
    parameter int   STABLE_TICKS = 4,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    logic                 meta_q, sync_q;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick_i) begin
            if (sync_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_WIDTH'(STABLE_TICKS - 1)) begin
                // Input has differed for STABLE_TICKS ticks in a row: accept it.
                level_d = sync_q;
                cnt_d   = '0;
                press_d = sync_q;
                rel_d   = ~sync_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            meta_q  <= RESET_BIT;
            sync_q  <= RESET_BIT;
            level_q <= RESET_BIT;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/buttons_reader.sv
// Debounced four-button reader: shared prescaler, per-button cells and a
// merging valid/ready event register.
module buttons_reader
    import buttons_pkg::*;
#(
    parameter int                     PRESCALER_WIDTH = 16,
    parameter int                     STABLE_TICKS    = 4,
    parameter logic [NUM_BUTTONS-1:0] RESET_LEVEL     = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    buttons_reader_if.master bus
);

    logic [PRESCALER_WIDTH-1:0] presc_q;
    logic                       tick;
    logic [NUM_BUTTONS-1:0]     level_w, press_w, rel_w;

    btn_evt_t evt_p;
    btn_evt_t evt_data_q, evt_data_d;
    logic     evt_valid_q, evt_valid_d;
    logic     ovr_q, ovr_d;
    logic     evt_any, evt_xfer;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) presc_q <= '0;
        else       presc_q <= presc_q + PRESCALER_WIDTH'(1);
    end

    assign tick = &presc_q;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_cell
            debounce_cell #(
                .STABLE_TICKS(STABLE_TICKS),
                .RESET_BIT   (RESET_LEVEL[gi])
            ) u_cell (
                .CLK      (CLK),
                .RSTN     (RSTN),
                .tick_i   (tick),
                .btn_i    (bus.BTN_IN[gi]),
                .level_o  (level_w[gi]),
                .press_o  (press_w[gi]),
                .release_o(rel_w[gi])
            );
        end
    endgenerate

    assign evt_p.release_m = rel_w;
    assign evt_p.press_m   = press_w;
    assign evt_any         = |evt_p;
    assign evt_xfer        = evt_valid_q & bus.EVT_READY;

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        ovr_d       = 1'b0;
        if (!evt_valid_q) begin
            if (evt_any) begin
                evt_data_d  = evt_p;
                evt_valid_d = 1'b1;
            end
        end else if (evt_xfer) begin
            if (evt_any) evt_data_d  = evt_p;
            else         evt_valid_d = 1'b0;
        end else if (evt_any) begin
            // Consumer is stalled: fold the new edges in and flag the merge.
            evt_data_d = evt_data_q | evt_p;
            ovr_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            ovr_q       <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.LEVEL       = level_w;
    assign bus.PRESS       = press_w;
    assign bus.RELEASE     = rel_w;
    assign bus.EVT_VALID   = evt_valid_q;
    assign bus.EVT_DATA    = evt_data_q;
    assign bus.EVT_OVERRUN = ovr_q;

endmodule

// File: tb/tb_buttons_reader.sv
// Directed and random checks of buttons_reader against a tick-counting reference model.
module tb_buttons_reader;
    import buttons_pkg::*;

    localparam int W   = 3;
    localparam int ST  = 4;
    localparam int PER = 1 << W;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    buttons_reader_if bus();

    buttons_reader #(
        .PRESCALER_WIDTH(W),
        .STABLE_TICKS   (ST),
        .RESET_LEVEL    (4'b0000)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_level, m_press, m_rel;
    logic       m_valid, m_ovr;
    logic [7:0] m_data;
    int         m_persist[4];
    int         m_edge;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'b0; m_s2 = 4'b0; m_level = 4'b0;
        m_press = 4'b0; m_rel = 4'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        for (int i = 0; i < 4; i++) m_persist[i] = 0;
        m_edge = 0;
    endtask

    // Called just after a rising edge with reset released; inputs are the pre-edge values.
    task automatic model_edge();
        logic [3:0] np, nr;
        logic [7:0] p;
        logic       tick, xfer;
        tick   = (m_edge % PER) == PER - 1;
        p      = {m_rel, m_press};
        xfer   = m_valid && bus.EVT_READY;
        m_ovr  = 1'b0;
        if (!m_valid) begin
            if (p != 0) begin m_data = p; m_valid = 1'b1; end
        end else if (xfer) begin
            if (p != 0) m_data = p;
            else        m_valid = 1'b0;
        end else if (p != 0) begin
            m_data = m_data | p;
            m_ovr  = 1'b1;
        end
        np = 4'b0; nr = 4'b0;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_level[i]) m_persist[i] = 0;
                else begin
                    m_persist[i]++;
                    if (m_persist[i] == ST) begin
                        m_level[i]   = m_s2[i];
                        m_persist[i] = 0;
                        if (m_s2[i]) np[i] = 1'b1;
                        else         nr[i] = 1'b1;
                    end
                end
            end
        end
        m_press = np;
        m_rel   = nr;
        m_s2    = m_s1;
        m_s1    = bus.BTN_IN;
        m_edge++;
    endtask

    task automatic check_all();
        chk4("level", bus.LEVEL, m_level);
        chk4("press", bus.PRESS, m_press);
        chk4("release", bus.RELEASE, m_rel);
        chk1("evt_valid", bus.EVT_VALID, m_valid);
        chk1("evt_overrun", bus.EVT_OVERRUN, m_ovr);
        if (m_valid || !RSTN) chk8("evt_data", bus.EVT_DATA, m_data);
    endtask

    task automatic step();
        @(posedge CLK);
        if (RSTN) model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_evt(input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((bus.PRESS | bus.RELEASE) == 4'b0 && n < lim);
    endtask

    initial begin
        int n, seen;
        logic [3:0] b;
        int hold;

        bus.BTN_IN    = 4'hF;
        bus.EVT_READY = 1'b0;
        RSTN          = 1'b0;
        model_reset();
        steps(5);
        chk4("rst_level", bus.LEVEL, 4'b0);
        chk1("rst_valid", bus.EVT_VALID, 1'b0);
        $display("reset held 5 cycles with BTN_IN=F");

        RSTN = 1'b1;
        steps(24);
        chk4("post_rst_level", bus.LEVEL, 4'b0);
        bus.BTN_IN = 4'b0;
        steps(16);
        $display("post-reset LEVEL held 0 for 24 cycles");

        // Clean press of button 2
        bus.BTN_IN    = 4'b0100;
        bus.EVT_READY = 1'b1;
        wait_evt(40, n);
        chk1("press_latency", n <= 34, 1'b1);
        chk4("press_mask", bus.PRESS, 4'b0100);
        step();
        chk4("press_width", bus.PRESS, 4'b0);
        chk1("press_evt_valid", bus.EVT_VALID, 1'b1);
        chk8("press_evt_data", bus.EVT_DATA, 8'h04);
        step();
        chk1("press_evt_taken", bus.EVT_VALID, 1'b0);
        $display("clean press latency=%0d cycles", n);

        // Glitch on button 0 shorter than the debounce window
        bus.BTN_IN = 4'b0101;
        steps(20);
        bus.BTN_IN = 4'b0100;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if ((bus.PRESS | bus.RELEASE) != 0 || bus.EVT_VALID) seen++;
        end
        chk_int("glitch_quiet", seen, 0);
        chk4("glitch_level", bus.LEVEL, 4'b0100);
        $display("glitch on BTN_IN[0] for 20 cycles ignored");

        bus.BTN_IN = 4'b0;
        wait_evt(40, n);
        chk4("rel2_mask", bus.RELEASE, 4'b0100);
        steps(3);

        // Simultaneous press and release of buttons 0 and 3
        bus.BTN_IN = 4'b1001;
        wait_evt(40, n);
        chk4("simul_press", bus.PRESS, 4'b1001);
        step();
        chk8("simul_press_data", bus.EVT_DATA, 8'h09);
        steps(3);
        bus.BTN_IN = 4'b0;
        wait_evt(40, n);
        step();
        chk8("simul_rel_data", bus.EVT_DATA, 8'h90);
        steps(3);
        $display("simultaneous press/release events 09/90");

        // Backpressure merge
        bus.EVT_READY = 1'b0;
        bus.BTN_IN    = 4'b0010;
        wait_evt(40, n);
        chk4("bp_press1", bus.PRESS, 4'b0010);
        step();
        chk8("bp_data1", bus.EVT_DATA, 8'h02);
        bus.BTN_IN = 4'b1010;
        wait_evt(40, n);
        chk4("bp_press3", bus.PRESS, 4'b1000);
        step();
        chk1("bp_overrun", bus.EVT_OVERRUN, 1'b1);
        chk8("bp_merged", bus.EVT_DATA, 8'h0A);
        step();
        chk1("bp_overrun_width", bus.EVT_OVERRUN, 1'b0);
        chk1("bp_still_valid", bus.EVT_VALID, 1'b1);
        bus.EVT_READY = 1'b1;
        step();
        chk1("bp_drained", bus.EVT_VALID, 1'b0);
        $display("backpressure merge to 0A with one overrun");

        bus.BTN_IN = 4'b0;
        steps(60);

        // Asynchronous reset with an event pending and a debounce in progress
        bus.EVT_READY = 1'b0;
        bus.BTN_IN    = 4'b0001;
        wait_evt(40, n);
        step();
        chk1("mid_valid", bus.EVT_VALID, 1'b1);
        bus.BTN_IN = 4'b0011;
        steps(18);
        RSTN = 1'b0;
        model_reset();
        #1;
        check_all();
        chk4("arst_level", bus.LEVEL, 4'b0);
        chk1("arst_valid", bus.EVT_VALID, 1'b0);
        steps(3);
        RSTN = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.LEVEL == 4'b0 && n < 40);
        chk_int("redebounce_cycles", n, 32);
        chk4("redebounce_level", bus.LEVEL, 4'b0011);
        $display("async reset mid-operation, re-debounce took %0d cycles", n);

        // Random stimulus against the model
        for (int t = 0; t < 60; t++) begin
            b    = 4'($urandom_range(0, 15));
            hold = (t % 3 == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(25, 60));
            bus.BTN_IN = b;
            for (int k = 0; k < hold; k++) begin
                bus.EVT_READY = ($urandom_range(0, 3) != 0);
                step();
            end
            $display("random btn=%h hold=%0d level=%h", b, hold, bus.LEVEL);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
